// File: rtl/iir_pkg.sv
// Shared constants, FSM encoding and address helpers for the IIR coefficient bank.
// A flat address is 5*section + k.
package iir_pkg;

    localparam int unsigned NUM_SECTIONS       = 3;
    localparam int unsigned COEFFS_PER_SECTION = 5;
    localparam int unsigned NUM_COEFFS         = NUM_SECTIONS * COEFFS_PER_SECTION;

    localparam int unsigned IDX_B0 = 0;
    localparam int unsigned IDX_B1 = 1;
    localparam int unsigned IDX_B2 = 2;
    localparam int unsigned IDX_A1 = 3;
    localparam int unsigned IDX_A2 = 4;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StPending = 1'b1
    } bank_state_e;

    // Unity gain in the fixed-point format; callers truncate to their word width.
    function automatic logic [63:0] identity_b0(input int unsigned scale_shift);
        return 64'd1 << scale_shift;
    endfunction

    function automatic logic [1:0] addr_section(input logic [3:0] addr);
        if (addr < 4'd5) begin
            return 2'd0;
        end else if (addr < 4'd10) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    function automatic logic [2:0] addr_coeff(input logic [3:0] addr);
        if (addr < 4'd5) begin
            return 3'(addr);
        end else if (addr < 4'd10) begin
            return 3'(addr - 4'd5);
        end
        return 3'(addr - 4'd10);
    endfunction

endpackage

// File: rtl/iir_coeff_section.sv
// One biquad section's worth of coefficients: five shadow and five active registers,
// with a shadow write port, a bulk shadow-to-active copy and a combinational read mux.
module iir_coeff_section
    import iir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = 32,
    parameter int unsigned SCALE_SHIFT = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [2:0]             wr_k,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic                   copy,
    input  logic [2:0]             rd_k,
    input  logic                   rd_active,
    output logic [COEFF_WIDTH-1:0] rd_data,
    output logic [COEFF_WIDTH-1:0] b0,
    output logic [COEFF_WIDTH-1:0] b1,
    output logic [COEFF_WIDTH-1:0] b2,
    output logic [COEFF_WIDTH-1:0] a1,
    output logic [COEFF_WIDTH-1:0] a2
);

    localparam logic [COEFF_WIDTH-1:0] B0_RESET = COEFF_WIDTH'(identity_b0(SCALE_SHIFT));

    logic [COEFF_WIDTH-1:0] shadow_q [COEFFS_PER_SECTION];
    logic [COEFF_WIDTH-1:0] active_q [COEFFS_PER_SECTION];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < COEFFS_PER_SECTION; k++) begin
                shadow_q[k] <= (k == IDX_B0) ? B0_RESET : '0;
                active_q[k] <= (k == IDX_B0) ? B0_RESET : '0;
            end
        end else begin
            if (wr_en) begin
                shadow_q[wr_k] <= wr_data;
            end
            if (copy) begin
                active_q <= shadow_q;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_k < 3'(COEFFS_PER_SECTION)) begin
            rd_data = rd_active ? active_q[rd_k] : shadow_q[rd_k];
        end
    end

    assign b0 = active_q[IDX_B0];
    assign b1 = active_q[IDX_B1];
    assign b2 = active_q[IDX_B2];
    assign a1 = active_q[IDX_A1];
    assign a2 = active_q[IDX_A2];

endmodule

// File: rtl/iir_coeff_bank.sv
// Double-buffered coefficient bank for a three-section IIR cascade; the shadow set is
// copied into the active set atomically on a sample_tick after a commit request.
module iir_coeff_bank
    import iir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = 32,
    parameter int unsigned SCALE_SHIFT = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    output logic                   wr_err,
    input  logic [3:0]             rd_addr,
    input  logic                   rd_sel,
    output logic [COEFF_WIDTH-1:0] rd_data,
    input  logic                   commit_req,
    input  logic                   sample_tick,
    output logic                   commit_pending,
    output logic                   commit_done,
    output logic                   dirty,
    output logic [COEFF_WIDTH-1:0] b0_s1,
    output logic [COEFF_WIDTH-1:0] b1_s1,
    output logic [COEFF_WIDTH-1:0] b2_s1,
    output logic [COEFF_WIDTH-1:0] a1_s1,
    output logic [COEFF_WIDTH-1:0] a2_s1,
    output logic [COEFF_WIDTH-1:0] b0_s2,
    output logic [COEFF_WIDTH-1:0] b1_s2,
    output logic [COEFF_WIDTH-1:0] b2_s2,
    output logic [COEFF_WIDTH-1:0] a1_s2,
    output logic [COEFF_WIDTH-1:0] a2_s2,
    output logic [COEFF_WIDTH-1:0] b0_s3,
    output logic [COEFF_WIDTH-1:0] b1_s3,
    output logic [COEFF_WIDTH-1:0] b2_s3,
    output logic [COEFF_WIDTH-1:0] a1_s3,
    output logic [COEFF_WIDTH-1:0] a2_s3
);

    bank_state_e state_q, state_d;

    logic                   wr_ok;
    logic                   copy;
    logic [1:0]             wr_sec;
    logic [2:0]             wr_k;
    logic [1:0]             rd_sec;
    logic [2:0]             rd_k;
    logic [COEFF_WIDTH-1:0] rd_data_d;

    logic                   wr_err_q;
    logic                   commit_done_q;
    logic                   dirty_q;
    logic [COEFF_WIDTH-1:0] rd_data_q;

    logic [COEFF_WIDTH-1:0] sec_rd [NUM_SECTIONS];
    logic [COEFF_WIDTH-1:0] sec_b0 [NUM_SECTIONS];
    logic [COEFF_WIDTH-1:0] sec_b1 [NUM_SECTIONS];
    logic [COEFF_WIDTH-1:0] sec_b2 [NUM_SECTIONS];
    logic [COEFF_WIDTH-1:0] sec_a1 [NUM_SECTIONS];
    logic [COEFF_WIDTH-1:0] sec_a2 [NUM_SECTIONS];

    assign wr_sec = addr_section(wr_addr);
    assign wr_k   = addr_coeff(wr_addr);
    assign rd_sec = addr_section(rd_addr);
    assign rd_k   = addr_coeff(rd_addr);

    // Writes are locked out while a commit waits, so the copied set cannot tear.
    assign wr_ok = wr_en && (state_q == StIdle) && (wr_addr < 4'(NUM_COEFFS));
    assign copy  = (state_q == StPending) && sample_tick;

    for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_section
        iir_coeff_section #(
            .COEFF_WIDTH(COEFF_WIDTH),
            .SCALE_SHIFT(SCALE_SHIFT)
        ) u_section (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_ok && (wr_sec == 2'(s))),
            .wr_k     (wr_k),
            .wr_data  (wr_data),
            .copy     (copy),
            .rd_k     (rd_k),
            .rd_active(rd_sel),
            .rd_data  (sec_rd[s]),
            .b0       (sec_b0[s]),
            .b1       (sec_b1[s]),
            .b2       (sec_b2[s]),
            .a1       (sec_a1[s]),
            .a2       (sec_a2[s])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (commit_req)  state_d = StPending;
            StPending: if (sample_tick) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_addr < 4'(NUM_COEFFS)) begin
            rd_data_d = sec_rd[rd_sec];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_err_q      <= 1'b0;
            commit_done_q <= 1'b0;
            dirty_q       <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_err_q      <= wr_en && !wr_ok;
            commit_done_q <= copy;
            rd_data_q     <= rd_data_d;
            if (copy) begin
                dirty_q <= 1'b0;
            end else if (wr_ok) begin
                dirty_q <= 1'b1;
            end
        end
    end

    assign wr_err         = wr_err_q;
    assign commit_done    = commit_done_q;
    assign commit_pending = (state_q == StPending);
    assign dirty          = dirty_q;
    assign rd_data        = rd_data_q;

    assign b0_s1 = sec_b0[0];
    assign b1_s1 = sec_b1[0];
    assign b2_s1 = sec_b2[0];
    assign a1_s1 = sec_a1[0];
    assign a2_s1 = sec_a2[0];
    assign b0_s2 = sec_b0[1];
    assign b1_s2 = sec_b1[1];
    assign b2_s2 = sec_b2[1];
    assign a1_s2 = sec_a1[1];
    assign a2_s2 = sec_a2[1];
    assign b0_s3 = sec_b0[2];
    assign b1_s3 = sec_b1[2];
    assign b2_s3 = sec_b2[2];
    assign a1_s3 = sec_a1[2];
    assign a2_s3 = sec_a2[2];

endmodule

// File: doc/iir_coeff_bank.md
# iir_coeff_bank

Double-buffered coefficient register bank feeding the three-section cascaded IIR filter directly upstream of its coefficient inputs. Host software writes 15 coefficients into a shadow bank one word at a time. On request, the whole set is copied atomically into the active bank on a sample boundary, so the filter never sees a torn mix of old and new sections. After reset, the active bank holds an identity filter (unity pass-through).

## Interface
- COEFF_WIDTH, 32, coefficient word width (signed)
- SCALE_SHIFT, 20, fixed-point fraction bits; the identity b0 equals 1 << SCALE_SHIFT
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  shadow write strobe
- wr_addr  in  4  coefficient index; address = 5*section + k, where section is 0..2 and k is 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
- wr_data  in  COEFF_WIDTH  coefficient value
- wr_err  out  1  one-cycle pulse; the write was rejected
- rd_addr  in  4  readback index
- rd_sel  in  1  readback bank select; 0 = shadow, 1 = active
- rd_data  out  COEFF_WIDTH  registered readback
- commit_req  in  1  request to copy shadow to active
- sample_tick  in  1  one-cycle pulse per filter input sample; tie high if no pacing is needed
- commit_pending  out  1  a commit is waiting for sample_tick
- commit_done  out  1  one-cycle pulse; the active bank has just been updated
- dirty  out  1  shadow has been written since the last commit
- b0_s1, b1_s1, b2_s1, a1_s1, a2_s1 … a2_s3  out  COEFF_WIDTH each  active-bank coefficients, one per filter coefficient input, driven directly from registers

## Operation
- The FSM has two states, IDLE and PENDING.
- IDLE, commit_req=1: next state is PENDING. A wr_en in the same cycle is accepted first and is included in the commit.
- PENDING, sample_tick=1: all 15 active registers load from shadow on this edge. Next state is IDLE. commit_done=1 and dirty=0 for the next cycle.
- PENDING, sample_tick=0: stay in PENDING.
- The copy never occurs in the same cycle commit_req is first seen. The earliest copy is on the following edge.
- commit_req while in PENDING is ignored; there is no queueing.
- Write acceptance:
  - Accepted only when state is IDLE and wr_addr is 0..14. Shadow[wr_addr] takes wr_data on the edge, and dirty is set.
  - Rejected when wr_addr is 15 or more, or when state is PENDING. Shadow is unchanged, and wr_err pulses on the next cycle.
- A commit with dirty=0 is still performed: the copy is idempotent and commit_done pulses.
- Readback:
  - rd_data is registered from bank[rd_sel][rd_addr].
  - rd_addr of 15 reads 0.
  - Reading shadow returns a write accepted on the previous edge.
- No arithmetic is performed. Values are stored and forwarded bit-exact, with no saturation.

## Timing
- Reset (asynchronous assert, synchronous-free release):
  - Every b0 register, shadow and active, resets to 1 << SCALE_SHIFT (0x00100000 at the defaults).
  - All other coefficients reset to 0.
  - State resets to IDLE. rd_data, wr_err, commit_done, commit_pending and dirty reset to 0.
- Reset during PENDING discards the commit and also reverts the shadow bank to identity.
- Latencies:
  - Write to shadow visible: 1 cycle.
  - rd_data: 1 cycle after rd_addr/rd_sel.
  - commit_pending rises 1 cycle after commit_req.
  - Active outputs change on the edge where PENDING and sample_tick are both high. commit_pending falls and commit_done rises on that same edge.
- Minimum commit_req-to-active-update latency is 2 cycles, with sample_tick high on the second cycle.
- The active outputs change only on a commit edge or on reset. They never change on a write.

## Structure
- The shared package iir_pkg holds:
  - NUM_SECTIONS=3, COEFFS_PER_SECTION=5, NUM_COEFFS=15
  - coefficient index constants IDX_B0 … IDX_A2
  - the FSM state encoding
  - the identity-value function of SCALE_SHIFT
- One sub-module, iir_coeff_section, holds 5 shadow plus 5 active registers with a write-enable, a copy strobe and a read mux. The top instantiates it 3 times and adds the FSM, address decode and rd_data register.

## Test plan
- Reset, then read the active bank for addresses 0..14 → addr 0, 5 and 10 read 0x00100000, all others 0. The b0_s* outputs equal 0x00100000.
- Write addr 7 = 0xFFF00000, with no commit → shadow readback is 0xFFF00000 and dirty=1. b2_s2 remains 0 for 100 cycles.
- commit_req with sample_tick held low for 10 cycles, then pulsed → commit_pending is high for those cycles. On the tick edge b2_s2 becomes 0xFFF00000, commit_done pulses once, and dirty=0.
- Write during PENDING to addr 3, and write to addr 15 in IDLE → wr_err pulses each time and the shadow is unchanged.
- Write addr 0 = 0x00080000 in the same cycle as commit_req, with sample_tick tied high → b0_s1 becomes 0x00080000 exactly 2 cycles later.
- Assert rst_n mid-PENDING → the outputs return to identity immediately, and no commit_done follows release.
